mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Multicycle MIPS main control unit. A registered FSM steps each instruction through fetch, decode, execute, memory and writeback. It drives the datapath muxes and the 4-bit ALU operation code (`ALUCtr`) into the 32-bit ALU, and samples that ALU's `Zero` flag to resolve `beq`. It sits between the instruction register and the shared datapath, which contains the single ALU, PC, memory, register file and `ALUOut` register.

## Interface
Parameters:
- `MEM_WAIT`, default 0: extra wait cycles added to every memory-access state. Legal range is 0..7.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `OpCode` input 6: IR[31:26].
- `Funct` input 6: IR[5:0].
- `Zero` input 1: ALU zero flag, combinational from `ALURes`.
- `ALUCtr` output 4: 0110 sub, 0010 add, 0000 and, 0001 or, 0111 slt.
- `ALUSrcA` output 1: 0 selects PC, 1 selects register A.
- `ALUSrcB` output 2: 00 register B, 01 constant 4, 10 extended immediate, 11 extended immediate << 2.
- `ExtOp` output 1: 1 sign-extend, 0 zero-extend.
- `PCSource` output 2: 00 `ALURes`, 01 `ALUOut`, 10 jump target.
- `PCWrite`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `RegDst`, `MemtoReg`, `RegWrite`: each output 1, datapath strobes and selects.
- `InstrDone` output 1: one-cycle pulse in the final state of each instruction.
- `Illegal` output 1: one-cycle pulse when decode rejects an instruction.

## Operation
- States: RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, RTYPE_WB, BEQ, JUMP, IMM_EX, IMM_WB, ILLEGAL.
- All outputs are Moore-decoded from the state register, with one exception: in BEQ, `PCWrite` = `Zero`.
- Any output not listed for a state is 0. Default `ALUCtr` is 0010 and default `ExtOp` is 1.
- RST:
  - All outputs 0, including `ALUCtr` = 0000.
  - Next state FETCH.
- FETCH:
  - `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, add, `PCSource`=00.
  - `IRWrite`=1 and `PCWrite`=1 only in the final wait cycle.
  - Next state DECODE.
- DECODE:
  - `ALUSrcA`=0, `ALUSrcB`=11, add (branch target into `ALUOut`).
  - Dispatch on opcode:
    - 000000 with a legal funct goes to RTYPE_EX.
    - 100011 (lw) and 101011 (sw) go to MEMADR.
    - 000100 goes to BEQ.
    - 000010 goes to JUMP.
    - 001000 (addi) and 001101 (ori) go to IMM_EX.
    - Anything else goes to ILLEGAL.
- RTYPE_EX:
  - `ALUSrcA`=1, `ALUSrcB`=00.
  - Funct to `ALUCtr`: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Next state RTYPE_WB.
- RTYPE_WB: `RegWrite`=1, `RegDst`=1, `MemtoReg`=0, `InstrDone`=1.
- MEMADR:
  - `ALUSrcA`=1, `ALUSrcB`=10, add.
  - lw goes to MEMRD; sw goes to MEMWR.
- MEMRD: `MemRead`=1, `IorD`=1, then MEMWB.
- MEMWB: `RegWrite`=1, `RegDst`=0, `MemtoReg`=1, `InstrDone`=1.
- MEMWR: `MemWrite`=1, `IorD`=1, `InstrDone`=1 in the final wait cycle only.
- BEQ:
  - `ALUSrcA`=1, `ALUSrcB`=00, sub, `PCSource`=01, `PCWrite`=`Zero`, `InstrDone`=1.
- JUMP: `PCWrite`=1, `PCSource`=10, `InstrDone`=1.
- IMM_EX:
  - `ALUSrcA`=1, `ALUSrcB`=10.
  - addi: add with `ExtOp`=1. ori: or with `ExtOp`=0.
- IMM_WB: `RegWrite`=1, `RegDst`=0, `MemtoReg`=0, `InstrDone`=1.
- ILLEGAL: `Illegal`=1, all other outputs 0.
- Every final state (including ILLEGAL) goes to FETCH.
- Wait counter:
  - 3 bits, loaded with `MEM_WAIT` on entry to FETCH, MEMRD or MEMWR.
  - The state holds while the counter is nonzero; the counter decrements each cycle.
  - `MemRead` and `MemWrite` stay asserted for every cycle of the state.
  - The counter is cleared by reset.

## Timing
- `reset` is sampled only at the rising edge of `clk`. Any cycle with `reset`=1 loads RST and clears the counter, even mid-instruction or mid-wait.
- The first FETCH occurs in the cycle after the first edge where `reset`=0 is sampled.
- Cycles per instruction, with `MEM_WAIT`=W:
  - lw: 5+2W.
  - sw: 4+2W.
  - R-type: 4+W.
  - addi and ori: 4+W.
  - beq: 3+W.
  - j: 3+W.
  - illegal: 3+W.
- `Zero` is combinational within the BEQ cycle, and the PC update lands at the end of that cycle. `PCWrite` must not glitch high outside BEQ.
- `Illegal` and `InstrDone` are never high in the same cycle.

## Configuration
- `MCCTRL_IMM_EN`:
  - Defined: IMM_EX and IMM_WB exist; addi and ori decode as legal.
  - Undefined: both states are removed; opcodes 001000 and 001101 go to ILLEGAL.

## Test plan
- Reset, then `OpCode`=000000, `Funct`=100010, W=0. Required: FETCH with `IRWrite` and `PCWrite` high, then DECODE, then RTYPE_EX with `ALUCtr`=0110, then RTYPE_WB with `RegWrite`=1 and `RegDst`=1, `InstrDone` high in cycle 4.
- lw (100011), W=2. Required:
  - FETCH lasts 3 cycles, with `IRWrite` only in the third.
  - MEMRD lasts 3 cycles.
  - MEMWB in cycle 9 with `MemtoReg`=1.
- beq with `Zero`=1, then beq with `Zero`=0. Required: BEQ state has `ALUCtr`=0110 and `PCSource`=01; `PCWrite`=1 in the first case and 0 in the second.
- ori (001101) with the macro defined. Required: `ALUCtr`=0001 and `ExtOp`=0 in IMM_EX. Same opcode with the macro undefined: ILLEGAL in cycle 3 with `Illegal`=1.
- `OpCode`=000000, `Funct`=000111. Required: ILLEGAL, then FETCH, with no `RegWrite` asserted.
- Assert `reset` during MEMWR while the wait counter is nonzero. Required: next cycle is RST with all outputs 0, then FETCH.

Source files
------------

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and the MIPS datapath.
// The master side is the controller; the slave side is the datapath/IR.
interface mips_multicycle_ctrl_if;
  logic [5:0] OpCode;
  logic [5:0] Funct;
  logic       Zero;
  logic [3:0] ALUCtr;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ExtOp;
  logic [1:0] PCSource;
  logic       PCWrite;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       InstrDone;
  logic       Illegal;

  modport master (
    input  OpCode, Funct, Zero,
    output ALUCtr, ALUSrcA, ALUSrcB, ExtOp, PCSource, PCWrite, IorD, MemRead,
           MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, InstrDone, Illegal
  );

  modport slave (
    output OpCode, Funct, Zero,
    input  ALUCtr, ALUSrcA, ALUSrcB, ExtOp, PCSource, PCWrite, IorD, MemRead,
           MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, InstrDone, Illegal
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM with registered Moore outputs and memory wait states.
// Define MCCTRL_IMM_EN to add the addi/ori execute and writeback states.
module mips_multicycle_ctrl #(
  parameter int MEM_WAIT = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  mips_multicycle_ctrl_if.master bus
);
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MCCTRL_IMM_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
`endif
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0111;

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTYPE_EX, S_RTYPE_WB, S_BEQ, S_JUMP,
`ifdef MCCTRL_IMM_EN
    S_IMM_EX, S_IMM_WB,
`endif
    S_ILLEGAL
  } state_t;

  typedef struct packed {
    logic [3:0] alu_ctr;
    logic       src_a;
    logic [1:0] src_b;
    logic       ext_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       instr_done;
    logic       illegal;
    logic       beq;
  } ctl_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  ctl_t       ctl_q, ctl_d;
  logic       funct_ok;
  logic [3:0] funct_alu;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (bus.Funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1; else state_d = S_DECODE;
      S_DECODE: begin
        case (bus.OpCode)
          OP_RTYPE:     state_d = funct_ok ? S_RTYPE_EX : S_ILLEGAL;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JUMP;
`ifdef MCCTRL_IMM_EN
          OP_ADDI, OP_ORI: state_d = S_IMM_EX;
`endif
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (bus.OpCode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1; else state_d = S_MEMWB;
      S_MEMWR:    if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1; else state_d = S_FETCH;
      S_RTYPE_EX: state_d = S_RTYPE_WB;
`ifdef MCCTRL_IMM_EN
      S_IMM_EX:   state_d = S_IMM_WB;
      S_IMM_WB:   state_d = S_FETCH;
`endif
      S_RTYPE_WB, S_MEMWB, S_BEQ, S_JUMP, S_ILLEGAL: state_d = S_FETCH;
      default:    state_d = S_RST;
    endcase
    // Counter reloads only on entry; while counting down state_d == state_q.
    if (state_d != state_q &&
        (state_d == S_FETCH || state_d == S_MEMRD || state_d == S_MEMWR))
      cnt_d = 3'(MEM_WAIT);

    // Outputs are decoded for the next state so they come straight off flops.
    ctl_d         = '0;
    ctl_d.alu_ctr = ALU_ADD;
    ctl_d.ext_op  = 1'b1;
    case (state_d)
      S_RST: begin
        ctl_d.alu_ctr = 4'b0000;
        ctl_d.ext_op  = 1'b0;
      end
      S_FETCH: begin
        ctl_d.mem_read = 1'b1;
        ctl_d.src_b    = 2'b01;
        ctl_d.pc_write = (cnt_d == 3'd0);
        ctl_d.ir_write = (cnt_d == 3'd0);
      end
      S_DECODE: ctl_d.src_b = 2'b11;
      S_MEMADR: begin
        ctl_d.src_a = 1'b1;
        ctl_d.src_b = 2'b10;
      end
      S_MEMRD: begin
        ctl_d.mem_read = 1'b1;
        ctl_d.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctl_d.reg_write  = 1'b1;
        ctl_d.mem_to_reg = 1'b1;
        ctl_d.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctl_d.mem_write  = 1'b1;
        ctl_d.iord       = 1'b1;
        ctl_d.instr_done = (cnt_d == 3'd0);
      end
      S_RTYPE_EX: begin
        ctl_d.src_a   = 1'b1;
        ctl_d.alu_ctr = funct_alu;
      end
      S_RTYPE_WB: begin
        ctl_d.reg_write  = 1'b1;
        ctl_d.reg_dst    = 1'b1;
        ctl_d.instr_done = 1'b1;
      end
      S_BEQ: begin
        ctl_d.src_a      = 1'b1;
        ctl_d.alu_ctr    = ALU_SUB;
        ctl_d.pc_src     = 2'b01;
        ctl_d.instr_done = 1'b1;
        ctl_d.beq        = 1'b1;
      end
      S_JUMP: begin
        ctl_d.pc_write   = 1'b1;
        ctl_d.pc_src     = 2'b10;
        ctl_d.instr_done = 1'b1;
      end
`ifdef MCCTRL_IMM_EN
      S_IMM_EX: begin
        ctl_d.src_a = 1'b1;
        ctl_d.src_b = 2'b10;
        if (bus.OpCode == OP_ORI) begin
          ctl_d.alu_ctr = ALU_OR;
          ctl_d.ext_op  = 1'b0;
        end
      end
      S_IMM_WB: begin
        ctl_d.reg_write  = 1'b1;
        ctl_d.instr_done = 1'b1;
      end
`endif
      S_ILLEGAL: begin
        ctl_d         = '0;
        ctl_d.illegal = 1'b1;
      end
      default: ctl_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RST;
      cnt_q   <= 3'd0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
    end
  end

  assign bus.ALUCtr    = ctl_q.alu_ctr;
  assign bus.ALUSrcA   = ctl_q.src_a;
  assign bus.ALUSrcB   = ctl_q.src_b;
  assign bus.ExtOp     = ctl_q.ext_op;
  assign bus.PCSource  = ctl_q.pc_src;
  // Only the registered BEQ flag can open the Zero path, so PCWrite cannot glitch elsewhere.
  assign bus.PCWrite   = ctl_q.pc_write | (ctl_q.beq & bus.Zero);
  assign bus.IorD      = ctl_q.iord;
  assign bus.MemRead   = ctl_q.mem_read;
  assign bus.MemWrite  = ctl_q.mem_write;
  assign bus.IRWrite   = ctl_q.ir_write;
  assign bus.RegDst    = ctl_q.reg_dst;
  assign bus.MemtoReg  = ctl_q.mem_to_reg;
  assign bus.RegWrite  = ctl_q.reg_write;
  assign bus.InstrDone = ctl_q.instr_done;
  assign bus.Illegal   = ctl_q.illegal;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench: per-cycle expected control vectors queued by stimulus, checked on negedge.
// Two instances cover MEM_WAIT=0 and MEM_WAIT=2 from shared inputs.
module tb_mips_multicycle_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_multicycle_ctrl_if if0 ();
  mips_multicycle_ctrl_if if2 ();

  mips_multicycle_ctrl #(.MEM_WAIT(0)) u0 (.clk(clk), .reset(reset), .bus(if0));
  mips_multicycle_ctrl #(.MEM_WAIT(2)) u2 (.clk(clk), .reset(reset), .bus(if2));

  // {ALUCtr, ALUSrcA, ALUSrcB, ExtOp, PCSource,
  //  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, InstrDone, Illegal}
  logic [19:0] act0, act2;
  assign act0 = {if0.ALUCtr, if0.ALUSrcA, if0.ALUSrcB, if0.ExtOp, if0.PCSource,
                 if0.PCWrite, if0.IorD, if0.MemRead, if0.MemWrite, if0.IRWrite,
                 if0.RegDst, if0.MemtoReg, if0.RegWrite, if0.InstrDone, if0.Illegal};
  assign act2 = {if2.ALUCtr, if2.ALUSrcA, if2.ALUSrcB, if2.ExtOp, if2.PCSource,
                 if2.PCWrite, if2.IorD, if2.MemRead, if2.MemWrite, if2.IRWrite,
                 if2.RegDst, if2.MemtoReg, if2.RegWrite, if2.InstrDone, if2.Illegal};

  localparam logic [19:0] E_RST      = {4'b0000, 1'b0, 2'b00, 1'b0, 2'b00, 10'b0000000000};
  localparam logic [19:0] E_FETCH_W  = {4'b0010, 1'b0, 2'b01, 1'b1, 2'b00, 10'b0010000000};
  localparam logic [19:0] E_FETCH_L  = {4'b0010, 1'b0, 2'b01, 1'b1, 2'b00, 10'b1010100000};
  localparam logic [19:0] E_DECODE   = {4'b0010, 1'b0, 2'b11, 1'b1, 2'b00, 10'b0000000000};
  localparam logic [19:0] E_RTEX_SUB = {4'b0110, 1'b1, 2'b00, 1'b1, 2'b00, 10'b0000000000};
  localparam logic [19:0] E_RTWB     = {4'b0010, 1'b0, 2'b00, 1'b1, 2'b00, 10'b0000010110};
  localparam logic [19:0] E_MEMADR   = {4'b0010, 1'b1, 2'b10, 1'b1, 2'b00, 10'b0000000000};
  localparam logic [19:0] E_MEMRD    = {4'b0010, 1'b0, 2'b00, 1'b1, 2'b00, 10'b0110000000};
  localparam logic [19:0] E_MEMWB    = {4'b0010, 1'b0, 2'b00, 1'b1, 2'b00, 10'b0000001110};
  localparam logic [19:0] E_MEMWR_W  = {4'b0010, 1'b0, 2'b00, 1'b1, 2'b00, 10'b0101000000};
  localparam logic [19:0] E_MEMWR_L  = {4'b0010, 1'b0, 2'b00, 1'b1, 2'b00, 10'b0101000010};
  localparam logic [19:0] E_BEQ_Z1   = {4'b0110, 1'b1, 2'b00, 1'b1, 2'b01, 10'b1000000010};
  localparam logic [19:0] E_BEQ_Z0   = {4'b0110, 1'b1, 2'b00, 1'b1, 2'b01, 10'b0000000010};
  localparam logic [19:0] E_JUMP     = {4'b0010, 1'b0, 2'b00, 1'b1, 2'b10, 10'b1000000010};
  localparam logic [19:0] E_ILL      = {4'b0000, 1'b0, 2'b00, 1'b0, 2'b00, 10'b0000000001};
`ifdef MCCTRL_IMM_EN
  localparam logic [19:0] E_ORI_EX   = {4'b0001, 1'b1, 2'b10, 1'b0, 2'b00, 10'b0000000000};
  localparam logic [19:0] E_IMM_WB   = {4'b0010, 1'b0, 2'b00, 1'b1, 2'b00, 10'b0000000110};
`endif

  typedef struct {
    string       name;
    logic [19:0] v;
  } exp_t;

  exp_t q0[$];
  exp_t q2[$];
  exp_t e0, e2;
  int n_chk  = 0;
  int n_fail = 0;

  always @(negedge clk) begin
    if (q0.size() > 0) begin
      e0 = q0.pop_front();
      n_chk++;
      if (act0 !== e0.v) begin
        n_fail++;
        $display("FAIL w0 %s: got %b want %b", e0.name, act0, e0.v);
      end
    end
    if (q2.size() > 0) begin
      e2 = q2.pop_front();
      n_chk++;
      if (act2 !== e2.v) begin
        n_fail++;
        $display("FAIL w2 %s: got %b want %b", e2.name, act2, e2.v);
      end
    end
  end

  task automatic set_in(input logic [5:0] op, input logic [5:0] fn, input logic z);
    if0.OpCode = op; if0.Funct = fn; if0.Zero = z;
    if2.OpCode = op; if2.Funct = fn; if2.Zero = z;
  endtask

  task automatic set_zero(input logic z);
    if0.Zero = z;
    if2.Zero = z;
  endtask

  // Queue the expectation for the cycle in progress, then step to just after the next edge.
  task automatic chk0(input string n, input logic [19:0] v);
    q0.push_back('{n, v});
    @(posedge clk); #1;
  endtask

  task automatic chk2(input string n, input logic [19:0] v);
    q2.push_back('{n, v});
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    set_in(6'b000000, 6'b100010, 1'b1);
    do_reset();

    // MEM_WAIT=0: R-type sub with Zero held high (PCWrite must stay off outside BEQ)
    chk0("rst", E_RST);
    chk0("sub_fetch", E_FETCH_L);
    chk0("sub_decode", E_DECODE);
    chk0("sub_ex", E_RTEX_SUB);
    chk0("sub_wb", E_RTWB);

    set_in(6'b000100, 6'b000000, 1'b0);
    chk0("beq1_fetch", E_FETCH_L);
    chk0("beq1_decode", E_DECODE);
    set_zero(1'b1);
    chk0("beq_taken", E_BEQ_Z1);

    chk0("beq2_fetch", E_FETCH_L);
    chk0("beq2_decode", E_DECODE);
    set_zero(1'b0);
    chk0("beq_not_taken", E_BEQ_Z0);

    set_in(6'b000000, 6'b000111, 1'b0);
    chk0("badfn_fetch", E_FETCH_L);
    chk0("badfn_decode", E_DECODE);
    chk0("badfn_illegal", E_ILL);

    set_in(6'b001101, 6'b000000, 1'b0);
    chk0("ori_fetch", E_FETCH_L);
    chk0("ori_decode", E_DECODE);
`ifdef MCCTRL_IMM_EN
    chk0("ori_ex", E_ORI_EX);
    chk0("ori_wb", E_IMM_WB);
`else
    chk0("ori_illegal", E_ILL);
`endif

    set_in(6'b000010, 6'b000000, 1'b1);
    chk0("j_fetch", E_FETCH_L);
    chk0("j_decode", E_DECODE);
    chk0("j_jump", E_JUMP);

    set_in(6'b101011, 6'b000000, 1'b0);
    chk0("sw0_fetch", E_FETCH_L);
    chk0("sw0_decode", E_DECODE);
    chk0("sw0_memadr", E_MEMADR);
    chk0("sw0_memwr", E_MEMWR_L);
    chk0("after_sw0_fetch", E_FETCH_L);

    // MEM_WAIT=2: lw timing, then reset mid-MEMWR wait
    set_in(6'b100011, 6'b000000, 1'b0);
    do_reset();
    chk2("rst", E_RST);
    chk2("lw_fetch_c1", E_FETCH_W);
    chk2("lw_fetch_c2", E_FETCH_W);
    chk2("lw_fetch_c3", E_FETCH_L);
    chk2("lw_decode", E_DECODE);
    chk2("lw_memadr", E_MEMADR);
    chk2("lw_memrd_c6", E_MEMRD);
    chk2("lw_memrd_c7", E_MEMRD);
    chk2("lw_memrd_c8", E_MEMRD);
    chk2("lw_memwb_c9", E_MEMWB);

    set_in(6'b101011, 6'b000000, 1'b0);
    chk2("sw_fetch_c1", E_FETCH_W);
    chk2("sw_fetch_c2", E_FETCH_W);
    chk2("sw_fetch_c3", E_FETCH_L);
    chk2("sw_decode", E_DECODE);
    chk2("sw_memadr", E_MEMADR);
    chk2("sw_memwr_c1", E_MEMWR_W);
    reset = 1'b1;
    chk2("sw_memwr_c2", E_MEMWR_W);
    reset = 1'b0;
    chk2("midwait_rst", E_RST);
    chk2("post_rst_fetch", E_FETCH_W);

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_chk);
    $fatal(1, "timeout");
  end
endmodule
